// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths and memory-port arbiter state encoding.
package cpu_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_D_BUSY = 2'd1;
  localparam logic [1:0] ARB_I_BUSY = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ARB_IDLE,
    S_D_BUSY = ARB_D_BUSY,
    S_I_BUSY = ARB_I_BUSY
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data access first, then instruction fetch, stalling the pipeline
// until both are done. Optional bus timeout enabled by MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              err_o
);

  arb_state_e        state_q, state_d;
  logic              d_done_q, d_done_d;
  logic              i_done_q, i_done_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_pend;
  logic              timeout;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  // cnt_q is the number of busy cycles already elapsed; the current one is number cnt_q+1.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign err_o   = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign d_pend  = mem_read_i | mem_write_i;
  assign stall_o = (d_pend & ~d_done_q) | (if_req_i & ~i_done_q);

  always_comb begin
    state_d     = state_q;
    d_done_d    = d_done_q;
    i_done_d    = i_done_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    mem_rdata_d = mem_rdata_q;
    if_rdata_d  = if_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (d_pend && !d_done_q) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
          state_d     = S_D_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end else if (if_req_i && !i_done_q) begin
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = if_addr_i;
          state_d    = S_I_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      S_D_BUSY, S_I_BUSY: begin
        if (bus_ack_i || timeout) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          state_d   = S_IDLE;
          // An aborted access completes with zero data so the pipeline can move on.
          if (state_q == S_D_BUSY) begin
            d_done_d = 1'b1;
            if (!bus_we_q) mem_rdata_d = bus_ack_i ? bus_rdata_i : '0;
          end else begin
            i_done_d   = 1'b1;
            if_rdata_d = bus_ack_i ? bus_rdata_i : '0;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          if (!bus_ack_i) err_d = 1'b1;
`endif
        end else begin
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!stall_o) begin
      d_done_d = 1'b0;
      i_done_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      d_done_q    <= 1'b0;
      i_done_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      mem_rdata_q <= '0;
      if_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      d_done_q    <= d_done_d;
      i_done_q    <= i_done_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_rdata_q  <= if_rdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign if_rdata_o  = if_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand-written corner sequences and randomized
// instruction steps checked against a transaction-level model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif
  localparam int BOUND = 200;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        mem_read_i, mem_write_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic        stall_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic        bus_ack_i, err_o;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .stall_o(stall_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .err_o(err_o)
  );

  always #5 sys_clk = ~sys_clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // dk: 0 none, 1 load, 2 store
  typedef struct {
    logic [1:0]  dk;
    logic        ir;
    logic [31:0] daddr, wdata, iaddr;
    int          dly0, dly1;
    logic [31:0] rd0, rd1;
    int          exp_stall, exp_ntx;
    logic [31:0] exp_mrd, exp_ird;
  } vec_t;

  // Expected-value model state: last data returned to each requester.
  logic [31:0] m_mrd = '0, m_ird = '0;

  // Runs one pipeline step: holds the inputs until stall_o drops, acting as the bus slave,
  // checks the issued transactions against the step's inputs, returns stall cycles.
  task automatic run_step(input string tag, input logic [1:0] dk, input logic ir,
                          input logic [31:0] daddr, input logic [31:0] wdata,
                          input logic [31:0] iaddr, input int dly0, input int dly1,
                          input logic [31:0] rd0, input logic [31:0] rd1,
                          output int stall_cyc, output int ntx);
    logic [31:0] ea[2], la[4], lw[4];
    logic        ew[2], lwe[4];
    int ne = 0, wcnt = 0, cyc;
    logic in_acc = 1'b0;
    ntx = 0;
    if (dk != 0) begin ea[ne] = daddr; ew[ne] = (dk == 2); ne++; end
    if (ir)      begin ea[ne] = iaddr; ew[ne] = 1'b0;      ne++; end
    mem_read_i = (dk == 1); mem_write_i = (dk == 2);
    mem_addr_i = daddr; mem_wdata_i = wdata;
    if_req_i = ir; if_addr_i = iaddr;
    bus_ack_i = 1'b0;
    for (cyc = 0; cyc < BOUND; cyc++) begin
      #1;
      if (!stall_o) break;
      if (bus_req_o) begin
        if (!in_acc) begin
          in_acc = 1'b1; wcnt = 0;
          if (ntx < 4) begin la[ntx] = bus_addr_o; lwe[ntx] = bus_we_o; lw[ntx] = bus_wdata_o; end
          ntx++;
        end else if (ntx <= 4) begin
          chk({tag, " addr_stable"}, bus_addr_o, la[ntx-1]);
          chk({tag, " we_stable"}, 32'(bus_we_o), 32'(lwe[ntx-1]));
          chk({tag, " wdata_stable"}, bus_wdata_o, lw[ntx-1]);
        end
        if (wcnt == ((ntx == 1) ? dly0 : dly1)) begin
          bus_ack_i = 1'b1; bus_rdata_i = (ntx == 1) ? rd0 : rd1; in_acc = 1'b0;
        end else wcnt++;
      end
      @(negedge sys_clk);
      bus_ack_i = 1'b0; bus_rdata_i = $urandom;
    end
    if (cyc >= BOUND) begin
      n_total++;
      $display("FAIL %s step_bound: stall_o never dropped within %0d cycles", tag, BOUND);
    end
    stall_cyc = cyc;
    chk({tag, " ntx"}, 32'(ntx), 32'(ne));
    for (int k = 0; k < ne && k < ntx && k < 4; k++) begin
      chk({tag, " tx_addr"}, la[k], ea[k]);
      chk({tag, " tx_we"}, 32'(lwe[k]), 32'(ew[k]));
      if (ew[k]) chk({tag, " tx_wdata"}, lw[k], wdata);
    end
    chk({tag, " err"}, 32'(err_o), 32'd0);
    @(negedge sys_clk);   // pipeline advance edge
  endtask

  vec_t vt[6];
  int   sc, nt;

  initial begin
    vt[0] = '{dk:1, ir:0, daddr:32'h100, wdata:0, iaddr:0, dly0:0, dly1:0, rd0:32'hDEADBEEF, rd1:0,
              exp_stall:2, exp_ntx:1, exp_mrd:32'hDEADBEEF, exp_ird:32'h0};
    vt[1] = '{dk:2, ir:1, daddr:32'h200, wdata:32'h55, iaddr:32'h40, dly0:0, dly1:0, rd0:32'hBAD0BAD0,
              rd1:32'h13, exp_stall:4, exp_ntx:2, exp_mrd:32'hDEADBEEF, exp_ird:32'h13};
    vt[2] = '{dk:1, ir:0, daddr:32'h104, wdata:0, iaddr:0, dly0:3, dly1:0, rd0:32'hCAFEF00D, rd1:0,
              exp_stall:5, exp_ntx:1, exp_mrd:32'hCAFEF00D, exp_ird:32'h13};
    vt[3] = '{dk:0, ir:1, daddr:0, wdata:0, iaddr:32'h44, dly0:1, dly1:0, rd0:32'h00A00093, rd1:0,
              exp_stall:3, exp_ntx:1, exp_mrd:32'hCAFEF00D, exp_ird:32'h00A00093};
    vt[4] = '{dk:1, ir:1, daddr:32'h108, wdata:0, iaddr:32'h48, dly0:2, dly1:0, rd0:32'h11111111,
              rd1:32'h22222222, exp_stall:6, exp_ntx:2, exp_mrd:32'h11111111, exp_ird:32'h22222222};
    vt[5] = '{dk:0, ir:0, daddr:0, wdata:0, iaddr:0, dly0:0, dly1:0, rd0:0, rd1:0,
              exp_stall:0, exp_ntx:0, exp_mrd:32'h11111111, exp_ird:32'h22222222};

    sys_rst = 1'b1; if_req_i = 0; if_addr_i = 0; mem_read_i = 0; mem_write_i = 0;
    mem_addr_i = 0; mem_wdata_i = 0; bus_rdata_i = 0; bus_ack_i = 0;
    repeat (2) @(negedge sys_clk);
    chk("rst bus_req", 32'(bus_req_o), 0);
    chk("rst bus_we", 32'(bus_we_o), 0);
    chk("rst bus_addr", bus_addr_o, 0);
    chk("rst mem_rdata", mem_rdata_o, 0);
    chk("rst if_rdata", if_rdata_o, 0);
    chk("rst stall", 32'(stall_o), 0);
    chk("rst err", 32'(err_o), 0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    for (int i = 0; i < 6; i++) begin
      run_step($sformatf("vec%0d", i), vt[i].dk, vt[i].ir, vt[i].daddr, vt[i].wdata, vt[i].iaddr,
               vt[i].dly0, vt[i].dly1, vt[i].rd0, vt[i].rd1, sc, nt);
      chk($sformatf("vec%0d stall_cycles", i), 32'(sc), 32'(vt[i].exp_stall));
      chk($sformatf("vec%0d mem_rdata", i), mem_rdata_o, vt[i].exp_mrd);
      chk($sformatf("vec%0d if_rdata", i), if_rdata_o, vt[i].exp_ird);
    end
    m_mrd = 32'h11111111; m_ird = 32'h22222222;

    // Spurious ack with no requests pending.
    mem_read_i = 0; mem_write_i = 0; if_req_i = 0;
    bus_ack_i = 1'b1; bus_rdata_i = 32'hA5A5A5A5;
    @(negedge sys_clk); bus_ack_i = 1'b0;
    chk("spur mem_rdata", mem_rdata_o, m_mrd);
    chk("spur if_rdata", if_rdata_o, m_ird);
    chk("spur bus_req", 32'(bus_req_o), 0);
    @(negedge sys_clk);
    chk("spur no_issue", 32'(bus_req_o), 0);

    // Reset while a load is on the bus; a late ack must be ignored.
    mem_read_i = 1; mem_addr_i = 32'h300;
    @(negedge sys_clk);
    chk("rmid busy_req", 32'(bus_req_o), 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("rmid bus_req", 32'(bus_req_o), 0);
    chk("rmid stall_raw", 32'(stall_o), 1);
    sys_rst = 1'b0; mem_read_i = 0;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h12345678;
    @(negedge sys_clk); bus_ack_i = 1'b0;
    chk("rmid late_ack", mem_rdata_o, 0);
    chk("rmid stall", 32'(stall_o), 0);
    chk("rmid idle", 32'(bus_req_o), 0);
    m_mrd = '0; m_ird = '0;

`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int hi = 0;
      mem_read_i = 1; mem_addr_i = 32'h500;
      for (int c = 0; c < 20 && stall_o; c++) begin
        #1; if (bus_req_o) hi++;
        @(negedge sys_clk);
      end
      chk("to req_cycles", 32'(hi), 32'(TO_CYC));
      chk("to stall", 32'(stall_o), 0);
      chk("to mem_rdata", mem_rdata_o, 0);
      chk("to err", 32'(err_o), 1);
      mem_read_i = 0;
      repeat (2) @(negedge sys_clk);
      chk("to err_sticky", 32'(err_o), 1);
      sys_rst = 1'b1; @(negedge sys_clk); sys_rst = 1'b0; @(negedge sys_clk);
    end
`endif

    // Randomized steps against the transaction-level model.
    for (int i = 0; i < 200; i++) begin
      logic [1:0]  dk;
      logic        ir;
      int          d0, d1, es;
      logic [31:0] r0, r1, da, ia, wd;
      dk = 2'($urandom_range(0, 2)); ir = 1'($urandom_range(0, 1));
      d0 = $urandom_range(0, 3); d1 = $urandom_range(0, 3);
      r0 = $urandom; r1 = $urandom; da = $urandom; ia = $urandom; wd = $urandom;
      es = 0;
      // Each access costs an issue cycle, its wait states and its ack cycle.
      if (dk != 0) begin
        es += 2 + d0;
        if (dk == 1) m_mrd = r0;
        if (ir) begin es += 2 + d1; m_ird = r1; end
      end else if (ir) begin
        es += 2 + d0; m_ird = r0;
      end
      run_step($sformatf("rnd%0d", i), dk, ir, da, wd, ia, d0, d1, r0, r1, sc, nt);
      chk($sformatf("rnd%0d stall_cycles", i), 32'(sc), 32'(es));
      chk($sformatf("rnd%0d mem_rdata", i), mem_rdata_o, m_mrd);
      chk($sformatf("rnd%0d if_rdata", i), if_rdata_o, m_ird);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory bus between instruction fetch (IF) and the MEM stage's load/store, driven by MemRead/MemWrite/ALU_result/RD_data from the EX/MEM pipeline register.
- Issues bus transactions and generates a global pipeline stall.
- Holds every pipeline register until the data access and the instruction access for the current cycle have both completed.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 255, cycles without bus_ack_i before abort (only with MEM_ARB_TIMEOUT_EN).

Ports:
- sys_clk  in  1  clock; all state updates on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- if_req_i  in  1  IF needs an instruction word.
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  fetched word, registered.
- mem_read_i  in  1  load pending in MEM stage.
- mem_write_i  in  1  store pending in MEM stage.
- mem_addr_i  in  ADDR_W  load/store address.
- mem_wdata_i  in  DATA_W  store data.
- mem_rdata_o  out  DATA_W  load data, registered.
- stall_o  out  1  freeze all pipeline registers and the PC.
- bus_req_o  out  1  bus request, registered.
- bus_we_o  out  1  write enable, registered.
- bus_addr_o  out  ADDR_W  bus address, registered.
- bus_wdata_o  out  DATA_W  bus write data, registered.
- bus_rdata_i  in  DATA_W  bus read data, valid with ack.
- bus_ack_i  in  1  one-cycle completion strobe.
- err_o  out  1  sticky timeout error.

Behaviour:
- Reset values: all outputs 0, state IDLE, d_done=0, i_done=0, counter 0. A reset mid-transaction drops bus_req_o at that edge; a late ack after reset is ignored.
- Internal terms:
  - d_pend = mem_read_i | mem_write_i.
  - stall_o (combinational) = (d_pend & ~d_done) | (if_req_i & ~i_done).
  - The pipeline advances when stall_o=0. On that edge, d_done and i_done both clear.
- FSM states: IDLE, D_BUSY, I_BUSY.
  - IDLE, d_pend & ~d_done: load bus_addr_o=mem_addr_i, bus_we_o=mem_write_i, bus_wdata_o=mem_wdata_i, bus_req_o=1; go to D_BUSY. Data has priority because it is the older instruction.
  - IDLE, else if if_req_i & ~i_done: load bus_addr_o=if_addr_i, bus_we_o=0, bus_req_o=1; go to I_BUSY.
  - IDLE, otherwise: stay.
  - D_BUSY/I_BUSY: bus outputs held stable until bus_ack_i.
  - On ack: bus_req_o←0, bus_we_o←0, set the matching done flag, return to IDLE.
  - Ack capture: loads write bus_rdata_i into mem_rdata_o; fetches write it into if_rdata_o; stores leave mem_rdata_o unchanged.
  - bus_ack_i is ignored in IDLE.
- Latency:
  - Single access with ack on the first bus_req_o cycle: stall_o high for 2 cycles (issue, ack), low on the 3rd.
  - Both accesses: data then instruction, serialized, with minimum 1 IDLE cycle between them.
- Done flags stop re-issue while the pipeline is still frozen by the other requester.
- mem_rdata_o and if_rdata_o hold until the next capture.
- Inputs are sampled only in IDLE; changes while busy have no effect on the bus.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit-plus counter (width $clog2(TIMEOUT_CYC+1)) counts cycles in D_BUSY/I_BUSY and clears on entry.
  - When count==TIMEOUT_CYC with no ack, the access aborts: bus_req_o←0, the done flag is set, captured data←0, err_o←1, state IDLE.
  - err_o stays set until sys_rst.
- Without the macro: no counter; the arbiter waits indefinitely; err_o is tied 0.

Decomposition:
- Shared package cpu_pkg:
  - state encoding localparams ARB_IDLE=2'd0, ARB_D_BUSY=2'd1, ARB_I_BUSY=2'd2.
  - ADDR_W/DATA_W defaults.
- No sub-module. The timeout counter is inline under the ifdef.

Test Plan:
- Load only: mem_read_i=1, mem_addr_i=0x100, ack on first req cycle with rdata=0xDEADBEEF -> bus_req_o 1 cycle with addr 0x100 and we=0; mem_rdata_o=0xDEADBEEF; stall_o high 2 cycles.
- Simultaneous store and fetch: mem_write_i=1, addr 0x200, wdata 0x55; if_req_i=1, addr 0x40 -> store issued first (we=1, wdata 0x55), then fetch at 0x40; stall_o drops only after the fetch ack; each access issued exactly once.
- Wait states: ack delayed 3 cycles -> bus_addr_o, bus_we_o and bus_wdata_o stable throughout; stall_o high 5 cycles total.
- Reset mid-op: sys_rst=1 while in D_BUSY -> next cycle bus_req_o=0, stall_o reflects only the raw inputs with done flags clear, state IDLE; a following ack is ignored.
- Spurious ack in IDLE: bus_ack_i=1 with no requests -> mem_rdata_o and if_rdata_o unchanged; no state change.
- Timeout, MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> bus_req_o drops after 4 busy cycles; err_o=1 and sticky; mem_rdata_o=0; pipeline advances.
